// File: rtl/gdp_popcount_param_pkg.sv
// ---------------------------------------------------------------------------
// gdp_popcount_param_pkg
// Shared definitions for the parametrised ones/zeros counter:
//   - gdp_state_e : controller state encodings (2 bits)
//   - GDP_MODE_*  : operand mode codes sampled with start
//   - gdp_cnt_w   : width of a count able to hold 0..width without overflow
// ---------------------------------------------------------------------------
package gdp_popcount_param_pkg;

    typedef enum logic [1:0] {
        GDP_S_IDLE = 2'd0,
        GDP_S_SCAN = 2'd1,
        GDP_S_DONE = 2'd2
    } gdp_state_e;

    localparam logic GDP_MODE_ONES  = 1'b0;
    localparam logic GDP_MODE_ZEROS = 1'b1;

    // Number of bits needed to represent every value 0..width inclusive.
    function automatic int gdp_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/gdp_popcount_param_chunk_pop.sv
// ---------------------------------------------------------------------------
// gdp_chunk_pop
// Combinational population count of one scan chunk.
// Ports:
//   i_bits  in  BITS_PER_CYCLE  chunk of the operand being consumed this cycle
//   o_cnt   out CNT_W           number of ones in i_bits, zero-extended
// ---------------------------------------------------------------------------
module gdp_chunk_pop #(
    parameter int BITS_PER_CYCLE = 1,
    parameter int CNT_W          = 4
) (
    input  logic [BITS_PER_CYCLE-1:0] i_bits,
    output logic [CNT_W-1:0]          o_cnt
);

    // Sum the chunk bits one at a time; the chunk is narrow so a ripple sum is fine.
    always_comb begin
        o_cnt = {CNT_W{1'b0}};
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            o_cnt = o_cnt + {{(CNT_W-1){1'b0}}, i_bits[i]};
        end
    end

endmodule

// File: rtl/gdp_popcount_param.sv
// ---------------------------------------------------------------------------
// gdp_popcount_param
// Parametrised ones/zeros counter with integrated controller. On start the
// operand (inverted for zeros mode) is loaded and scanned BITS_PER_CYCLE bits
// per clock; the scan stops as soon as the remaining operand is zero, and the
// count is then presented with a held done level until the next start.
// Ports:
//   clock      in   1      rising-edge clock
//   restart_n  in   1      asynchronous active-low reset
//   start      in   1      request, honoured only in IDLE or DONE
//   mode       in   1      0 = count ones, 1 = count zeros (sampled with start)
//   n_in       in   WIDTH  operand (sampled with start)
//   busy       out  1      high while scanning
//   done       out  1      high while the result is presented
//   run_sum    out  CNT_W  result while done, otherwise 0
// ---------------------------------------------------------------------------
module gdp_popcount_param
    import gdp_popcount_param_pkg::*;
#(
    parameter  int WIDTH          = 8,
    parameter  int BITS_PER_CYCLE = 1,
    localparam int CNT_W          = gdp_cnt_w(WIDTH)
) (
    input  logic             clock,
    input  logic             restart_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] n_in,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] run_sum
);

    if (WIDTH < 2) begin : g_bad_width
        $error("gdp_popcount_param: WIDTH must be at least 2");
    end
    if ((WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_chunk
        $error("gdp_popcount_param: BITS_PER_CYCLE must divide WIDTH");
    end

    gdp_state_e         r_state;
    gdp_state_e         w_state_nxt;
    logic [WIDTH-1:0]   r_n;
    logic [WIDTH-1:0]   w_n_nxt;
    logic [CNT_W-1:0]   r_acc;
    logic [CNT_W-1:0]   w_acc_nxt;
    logic [CNT_W-1:0]   w_chunk_cnt;

    gdp_chunk_pop #(
        .BITS_PER_CYCLE (BITS_PER_CYCLE),
        .CNT_W          (CNT_W)
    ) u_chunk_pop (
        .i_bits (r_n[BITS_PER_CYCLE-1:0]),
        .o_cnt  (w_chunk_cnt)
    );

    // Next-state, operand and accumulator update for the scan controller.
    always_comb begin
        w_state_nxt = r_state;
        w_n_nxt     = r_n;
        w_acc_nxt   = r_acc;
        case (r_state)
            GDP_S_IDLE, GDP_S_DONE: begin
                // DONE reloads directly so back-to-back operations skip IDLE.
                if (start) begin
                    w_n_nxt     = (mode == GDP_MODE_ZEROS) ? ~n_in : n_in;
                    w_acc_nxt   = {CNT_W{1'b0}};
                    w_state_nxt = GDP_S_SCAN;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            GDP_S_SCAN: begin
                // Early exit: once no ones remain, further chunks add nothing.
                if (r_n == {WIDTH{1'b0}}) begin
                    w_state_nxt = GDP_S_DONE;
                end else begin
                    w_acc_nxt = r_acc + w_chunk_cnt;
                    w_n_nxt   = r_n >> BITS_PER_CYCLE;
                end
            end
            default: begin
                w_state_nxt = GDP_S_IDLE;
                w_n_nxt     = {WIDTH{1'b0}};
                w_acc_nxt   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, operand and accumulator registers.
    always_ff @(posedge clock or negedge restart_n) begin
        if (!restart_n) begin
            r_state <= GDP_S_IDLE;
            r_n     <= {WIDTH{1'b0}};
            r_acc   <= {CNT_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_n     <= w_n_nxt;
            r_acc   <= w_acc_nxt;
        end
    end

    // Outputs are registered from the next-state view so they track r_state
    // exactly; run_sum is gated to zero outside DONE.
    always_ff @(posedge clock or negedge restart_n) begin
        if (!restart_n) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            run_sum <= {CNT_W{1'b0}};
        end else begin
            busy    <= (w_state_nxt == GDP_S_SCAN);
            done    <= (w_state_nxt == GDP_S_DONE);
            run_sum <= (w_state_nxt == GDP_S_DONE) ? w_acc_nxt : {CNT_W{1'b0}};
        end
    end

endmodule
